// File: rtl/noc_wf_allocator_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_wf_allocator_rr: registered NxN wavefront switch allocator with      |
// | rotating diagonal priority, wormhole output locks and credit stall mask. |
// | Optional macro NOC_ALLOC_PERF_CNT_EN adds saturating perf counters.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module noc_wf_allocator_rr #(
  parameter  int DIM_N = 8,
  localparam int DIMW  = $clog2(DIM_N)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [DIM_N-1:0][DIM_N-1:0]  req_i,
  input  logic [DIM_N-1:0]             tail_i,
  input  logic [DIM_N-1:0]             stall_i,
  output logic [DIM_N-1:0][DIM_N-1:0]  grn_o,
  output logic                         grn_vld_o,
  output logic [DIMW-1:0]              prio_o,
  output logic [DIM_N-1:0]             lock_o
`ifdef NOC_ALLOC_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_grant_cnt_o,
  output logic [31:0]                  perf_conflict_cnt_o
`endif
);

  logic [DIM_N-1:0][DIMW-1:0]  owner;
  logic [DIM_N-1:0][DIMW-1:0]  owner_nxt;
  logic [DIM_N-1:0]            lock_nxt;
  logic [DIM_N-1:0]            owns_lock;
  logic [DIM_N-1:0][DIM_N-1:0] cont_grn;
  logic [DIM_N-1:0][DIM_N-1:0] elig;
  logic [DIM_N-1:0][DIM_N-1:0] new_grn;
  logic [DIM_N-1:0][DIM_N-1:0] grn_nxt;
  logic [DIM_N-1:0]            row_free;
  logic [DIM_N-1:0]            col_free;
  logic [DIMW-1:0]             prio_nxt;
  logic                        any_new;

  // Locked outputs bypass the wavefront: the owner keeps its column unless stalled.
  always_comb begin
    owns_lock = '0;
    cont_grn  = '0;
    for (int j = 0; j < DIM_N; j++) begin
      for (int i = 0; i < DIM_N; i++) begin
        if (lock_o[j] && owner[j] == DIMW'(i)) begin
          owns_lock[i]   = 1'b1;
          cont_grn[i][j] = req_i[i][j] && !stall_i[j];
        end
      end
    end
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < DIM_N; i++) begin
      for (int j = 0; j < DIM_N; j++) begin
        elig[i][j] = req_i[i][j] && !lock_o[j] && !stall_i[j] && !owns_lock[i];
      end
    end
  end

  // Diagonals are swept starting at prio_o; cells on one diagonal never share a row or column.
  always_comb begin
    new_grn  = '0;
    row_free = '1;
    col_free = '1;
    for (int k = 0; k < DIM_N; k++) begin
      for (int i = 0; i < DIM_N; i++) begin
        for (int j = 0; j < DIM_N; j++) begin
          if ((((i + DIM_N - j) % DIM_N) == ((int'(prio_o) + k) % DIM_N)) &&
              elig[i][j] && row_free[i] && col_free[j]) begin
            new_grn[i][j] = 1'b1;
            row_free[i]   = 1'b0;
            col_free[j]   = 1'b0;
          end
        end
      end
    end
  end

  assign any_new  = |new_grn;
  assign grn_nxt  = new_grn | cont_grn;
  assign prio_nxt = (prio_o == DIMW'(DIM_N - 1)) ? '0 : prio_o + DIMW'(1);

  always_comb begin
    lock_nxt  = lock_o;
    owner_nxt = owner;
    for (int j = 0; j < DIM_N; j++) begin
      for (int i = 0; i < DIM_N; i++) begin
        if (grn_o[i][j]) begin
          if (tail_i[i]) begin
            lock_nxt[j] = 1'b0;
          end else begin
            lock_nxt[j]  = 1'b1;
            owner_nxt[j] = DIMW'(i);
          end
        end
      end
      // A withdrawn request aborts the packet even if a body grant is showing.
      for (int i = 0; i < DIM_N; i++) begin
        if (lock_o[j] && owner[j] == DIMW'(i) && !req_i[i][j]) begin
          lock_nxt[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      grn_o     <= '0;
      grn_vld_o <= 1'b0;
      prio_o    <= '0;
      lock_o    <= '0;
      owner     <= '0;
    end else begin
      grn_o     <= grn_nxt;
      grn_vld_o <= |grn_nxt;
      lock_o    <= lock_nxt;
      owner     <= owner_nxt;
      if (any_new) begin
        prio_o <= prio_nxt;
      end
    end
  end

`ifdef NOC_ALLOC_PERF_CNT_EN
  logic [5:0]  grant_pop;
  logic [32:0] grant_sum;
  logic        conflict_hit;

  always_comb begin
    grant_pop = '0;
    for (int i = 0; i < DIM_N; i++) begin
      for (int j = 0; j < DIM_N; j++) begin
        grant_pop = grant_pop + 6'(new_grn[i][j]);
      end
    end
  end

  assign grant_sum    = {1'b0, perf_grant_cnt_o} + 33'(grant_pop);
  assign conflict_hit = |(elig & ~new_grn);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_grant_cnt_o    <= '0;
      perf_conflict_cnt_o <= '0;
    end else begin
      perf_grant_cnt_o <= grant_sum[32] ? '1 : grant_sum[31:0];
      if (conflict_hit && perf_conflict_cnt_o != '1) begin
        perf_conflict_cnt_o <= perf_conflict_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_wf_allocator_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_noc_wf_allocator_rr: self-checking bench for noc_wf_allocator_rr      |
// | (DIM_N=4); perf ports checked when NOC_ALLOC_PERF_CNT_EN is defined.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_noc_wf_allocator_rr;
  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_ni;
  logic [N-1:0][N-1:0]  req;
  logic [N-1:0]         tail;
  logic [N-1:0]         stall;
  logic [N-1:0][N-1:0]  grn;
  logic                 grn_vld;
  logic [W-1:0]         prio;
  logic [N-1:0]         lock;
`ifdef NOC_ALLOC_PERF_CNT_EN
  logic [31:0]          perf_g;
  logic [31:0]          perf_c;
`endif

  noc_wf_allocator_rr #(.DIM_N(N)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .req_i     (req),
    .tail_i    (tail),
    .stall_i   (stall),
    .grn_o     (grn),
    .grn_vld_o (grn_vld),
    .prio_o    (prio),
    .lock_o    (lock)
`ifdef NOC_ALLOC_PERF_CNT_EN
    ,
    .perf_grant_cnt_o    (perf_g),
    .perf_conflict_cnt_o (perf_c)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  bit     mg [N][N];
  bit     ml [N];
  int     mo [N];
  int     mp;
  longint mpg;
  longint mpc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit el [N][N];
    bit ng [N][N];
    bit rowf [N];
    bit colf [N];
    bit owns [N];
    bit nl [N];
    int no [N];
    int cnt;
    bit confl;
    if (!rst_ni) begin
      foreach (mg[i, j]) mg[i][j] = 0;
      foreach (ml[j]) begin ml[j] = 0; mo[j] = 0; end
      mp = 0; mpg = 0; mpc = 0;
      return;
    end
    foreach (owns[i]) owns[i] = 0;
    foreach (ml[j]) if (ml[j]) owns[mo[j]] = 1;
    foreach (el[i, j]) begin
      el[i][j] = req[i][j] && !ml[j] && !stall[j] && !owns[i];
      ng[i][j] = 0;
    end
    foreach (rowf[i]) begin rowf[i] = 1; colf[i] = 1; end
    for (int k = 0; k < N; k++) begin
      int d = (mp + k) % N;
      for (int i = 0; i < N; i++) begin
        int j = (i - d + N) % N;
        if (el[i][j] && rowf[i] && colf[j]) begin
          ng[i][j] = 1; rowf[i] = 0; colf[j] = 0;
        end
      end
    end
    cnt = 0; confl = 0;
    foreach (ng[i, j]) begin
      cnt += int'(ng[i][j]);
      if (el[i][j] && !ng[i][j]) confl = 1;
    end
    for (int j = 0; j < N; j++) begin
      nl[j] = ml[j]; no[j] = mo[j];
      for (int i = 0; i < N; i++)
        if (mg[i][j]) begin
          if (tail[i]) nl[j] = 0;
          else begin nl[j] = 1; no[j] = i; end
        end
      if (ml[j] && !req[mo[j]][j]) nl[j] = 0;
    end
    foreach (mg[i, j]) mg[i][j] = ng[i][j] || (ml[j] && mo[j] == i && req[i][j] && !stall[j]);
    foreach (ml[j]) begin ml[j] = nl[j]; mo[j] = no[j]; end
    if (cnt > 0) mp = (mp + 1) % N;
    mpg = (mpg + cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mpg + cnt;
    if (confl && mpc < 64'hFFFF_FFFF) mpc++;
  endtask

  task automatic compare_all();
    logic [N-1:0][N-1:0] eg;
    logic [N-1:0]        el;
    bit                  any;
    any = 0;
    foreach (mg[i, j]) begin eg[i][j] = mg[i][j]; any |= mg[i][j]; end
    foreach (ml[j]) el[j] = ml[j];
    chk("grn", 32'(grn), 32'(eg));
    chk("grn_vld", 32'(grn_vld), 32'(any));
    chk("prio", 32'(prio), 32'(mp));
    chk("lock", 32'(lock), 32'(el));
`ifdef NOC_ALLOC_PERF_CNT_EN
    chk("perf_grant", perf_g, mpg[31:0]);
    chk("perf_conflict", perf_c, mpc[31:0]);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    cycle();
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic [15:0] req;
    logic [3:0]  tail;
    logic [3:0]  stall;
    logic [15:0] exp_grn;
    logic [1:0]  exp_prio;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{16'hFFFF, 4'hF, 4'h0, 16'h8421, 2'd1};
    tbl[1] = '{16'hFFFF, 4'hF, 4'h0, 16'h4218, 2'd2};
    tbl[2] = '{16'hFFFF, 4'hF, 4'h0, 16'h2184, 2'd3};
    tbl[3] = '{16'hFFFF, 4'hF, 4'h0, 16'h1842, 2'd0};
    tbl[4] = '{16'hFFFF, 4'hF, 4'h0, 16'h8421, 2'd1};

    // Reset held with all requests active
    rst_ni = 1'b0;
    req    = '1;
    tail   = '1;
    stall  = '0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("rst_grn", 32'(grn), 32'd0);
      chk("rst_prio", 32'(prio), 32'd0);
      chk("rst_lock", 32'(lock), 32'd0);
    end
    rst_ni = 1'b1;

    // Full contention: diagonal p is granted, priority rotates
    for (int v = 0; v < 5; v++) begin
      req   = tbl[v].req;
      tail  = tbl[v].tail;
      stall = tbl[v].stall;
      cycle();
      chk("tbl_grn", 32'(grn), 32'(tbl[v].exp_grn));
      chk("tbl_prio", 32'(prio), 32'(tbl[v].exp_prio));
    end
`ifdef NOC_ALLOC_PERF_CNT_EN
    chk("perf_grant_20", perf_g, 32'd20);
    chk("perf_conflict_5", perf_c, 32'd5);
`endif

    // Single-column conflict
    do_reset();
    req = '0; req[0][2] = 1'b1; req[3][2] = 1'b1;
    tail = '1; stall = '0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("col2_single", 32'(grn[0][2] & grn[3][2]), 32'd0);
      chk("col2_vld", 32'(grn_vld), 32'd1);
    end

    // Packet lock: input 1 holds output 0 against input 2
    do_reset();
    req = '0; req[1][0] = 1'b1; req[2][0] = 1'b1;
    tail = 4'b0100; stall = '0;
    cycle(); chk("pkt_a_in2", 32'(grn[2][0]), 32'd0);
    cycle(); chk("pkt_b_lock", 32'(lock[0]), 32'd1);
             chk("pkt_b_in2", 32'(grn[2][0]), 32'd0);
    cycle(); chk("pkt_c_lock", 32'(lock[0]), 32'd1);
             chk("pkt_c_in2", 32'(grn[2][0]), 32'd0);
    tail[1] = 1'b1;
    cycle(); chk("pkt_d_unlock", 32'(lock[0]), 32'd0);
             chk("pkt_d_in1", 32'(grn[1][0]), 32'd1);
             chk("pkt_d_in2", 32'(grn[2][0]), 32'd0);
    req[1][0] = 1'b0;
    cycle(); chk("pkt_e_in2", 32'(grn[2][0]), 32'd1);

    // Stall on a locked output, then abort
    do_reset();
    req = '0; req[0][2] = 1'b1;
    tail = '0; stall = '0;
    cycle();
    cycle(); chk("stl_lock", 32'(lock[2]), 32'd1);
    stall[2] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      chk("stl_grn0", 32'(grn[0][2]), 32'd0);
      chk("stl_held", 32'(lock[2]), 32'd1);
    end
    stall[2] = 1'b0;
    cycle(); chk("stl_resume", 32'(grn[0][2]), 32'd1);
    req[0][2] = 1'b0;
    cycle(); chk("abort_lock", 32'(lock[2]), 32'd0);
             chk("abort_grn", 32'(grn), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_ni = ($urandom_range(0, 63) != 0);
      req    = 16'($urandom() & $urandom());
      tail   = 4'($urandom());
      stall  = 4'($urandom() & $urandom() & $urandom());
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
